// File: rtl/vsc_pkg.sv
// Shared types and constants for the vector sweep checker.
// Holds the FSM state encoding, the MISR constants and the expected-table lookup helper.
package vsc_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // Widest expected table the lookup helper accepts (N_OUT * 2**N_IN bits).
  localparam int EXP_MAX_W = 256;

  // Table layout: bit [o*n_vec + idx] = expected output o at vector idx.
  function automatic logic exp_bit(input logic [EXP_MAX_W-1:0] exp_tbl, input int o,
                                   input int idx, input int n_vec = 16);
    logic [EXP_MAX_W-1:0] shifted;
    shifted = exp_tbl >> (o * n_vec + idx);
    return shifted[0];
  endfunction

endpackage

// File: rtl/vsc_misr.sv
// 16-bit multiple-input signature register (x^16+x^12+x^5+1).
// The sampled outputs are folded into the low bits on every shift.
module vsc_misr
  import vsc_pkg::*;
#(
  parameter int N_OUT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             shift,
  input  logic [N_OUT-1:0] din,
  output logic [15:0]      sig
);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      sig <= MISR_SEED;
    end else if (shift) begin
      sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ 16'(din);
    end
  end

endmodule

// File: rtl/vector_sweep_checker.sv
// Exhaustive stimulus driver and response checker for small combinational circuits.
// Optional signature output sig_o is enabled by defining SIGNATURE_EN.
module vector_sweep_checker
  import vsc_pkg::*;
#(
  parameter int                         N_IN   = 4,
  parameter int                         N_OUT  = 2,
  parameter int                         SETTLE = 2,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXP    = 32'h8888_0FF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  vec_o,
  input  logic [N_OUT-1:0] f_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_cnt,
  output logic [N_IN-1:0]  first_err_idx
`ifdef SIGNATURE_EN
  ,
  output logic [15:0]      sig_o
`endif
);

  localparam int                    N_VEC    = 2 ** N_IN;
  localparam logic [N_IN-1:0]       LAST_IDX = N_IN'(N_VEC - 1);
  localparam int                    CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [EXP_MAX_W-1:0]  EXP_EXT  = EXP_MAX_W'(EXP);
  localparam state_t                VEC_ENTRY = (SETTLE == 0) ? SAMPLE : DRIVE;

  state_t           state, state_nxt;
  logic [N_IN-1:0]  idx;
  logic [CW-1:0]    settle_cnt;
  logic             clear;
  logic             sampling;
  logic             mismatch;
  logic [N_OUT-1:0] exp_vec;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = VEC_ENTRY;
        end
      end
      DRIVE:   if (settle_cnt == CNT_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == LAST_IDX) ? DONE : VEC_ENTRY;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    exp_vec = '0;
    for (int o = 0; o < N_OUT; o++) exp_vec[o] = exp_bit(EXP_EXT, o, int'(idx), N_VEC);
  end

  assign sampling = (state == SAMPLE);
  assign mismatch = sampling && (f_i != exp_vec);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      settle_cnt    <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        idx           <= '0;
        settle_cnt    <= '0;
        err_cnt       <= '0;
        first_err_idx <= '0;
      end else if (state == DRIVE) begin
        settle_cnt <= (settle_cnt == CNT_LAST) ? '0 : settle_cnt + 1'b1;
      end else if (sampling) begin
        if (mismatch) begin
          err_cnt <= err_cnt + 1'b1;
          if (err_cnt == '0) first_err_idx <= idx;
        end
        // idx freezes on the last vector so vec_o holds while DONE.
        if (idx != LAST_IDX) idx <= idx + 1'b1;
      end
    end
  end

  assign vec_o = idx;
  assign busy  = (state == DRIVE) || (state == SAMPLE);
  assign done  = (state == DONE);
  assign pass  = done && (err_cnt == '0);

`ifdef SIGNATURE_EN
  vsc_misr #(.N_OUT(N_OUT)) u_misr (
    .clk  (clk),
    .rst  (rst),
    .init (clear),
    .shift(sampling),
    .din  (f_i),
    .sig  (sig_o)
  );
`endif

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Self-checking bench for vector_sweep_checker: lab model F1=A^B, F2=C&D, fault injection,
// random fault tables and a delayed-output model against SETTLE=2 and SETTLE=0 instances.
module tb_vector_sweep_checker;

  logic       clk = 1'b0;
  logic       rst, start, start0;
  logic [3:0] vec, vec0, first, first0;
  logic [1:0] f, f0, f_dly, f0_dly;
  logic       busy, done, pass, busy0, done0, pass0;
  logic [4:0] err, err0;
`ifdef SIGNATURE_EN
  logic [15:0] sig, sig0, golden_sig;
`endif

  int          checks = 0;
  int          errors = 0;
  int          mode;    // 0: golden ^ flip, 1: one-cycle delayed golden, 2: F2 stuck-at-0
  logic [31:0] flip;

  always #5 clk = ~clk;

  vector_sweep_checker #(.N_IN(4), .N_OUT(2), .SETTLE(2), .EXP(32'h8888_0FF0)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_o(vec), .f_i(f), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err), .first_err_idx(first)
`ifdef SIGNATURE_EN
    , .sig_o(sig)
`endif
  );

  vector_sweep_checker #(.N_IN(4), .N_OUT(2), .SETTLE(0), .EXP(32'h8888_0FF0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec_o(vec0), .f_i(f0), .busy(busy0), .done(done0),
    .pass(pass0), .err_cnt(err0), .first_err_idx(first0)
`ifdef SIGNATURE_EN
    , .sig_o(sig0)
`endif
  );

  // Lab circuit: bit0 = F1 = A^B, bit1 = F2 = C&D, with A = v[3] .. D = v[0].
  function automatic logic [1:0] golden(input logic [3:0] v);
    return {v[1] & v[0], v[3] ^ v[2]};
  endfunction

  function automatic logic [1:0] flip_at(input logic [31:0] m, input int i);
    logic [31:0] s;
    s = m >> i;
    return {s[16], s[0]};
  endfunction

  // Value the circuit presents while vector i has been held for at least one cycle.
  function automatic logic [1:0] model_sample(input int i);
    logic [1:0] g;
    g = golden(4'(i));
    case (mode)
      1:       return g;
      2:       return {1'b0, g[0]};
      default: return g ^ flip_at(flip, i);
    endcase
  endfunction

  function automatic logic [15:0] misr_ref(input logic [1:0] s [16]);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 0; i < 16; i++) r = ((r << 1) ^ (r[15] ? 16'h1021 : 16'h0000)) ^ {14'd0, s[i]};
    return r;
  endfunction

  function automatic logic [15:0] model_sig();
    logic [1:0] s [16];
    for (int i = 0; i < 16; i++) s[i] = model_sample(i);
    return misr_ref(s);
  endfunction

  always @(posedge clk) begin
    f_dly  <= golden(vec);
    f0_dly <= golden(vec0);
  end

  always_comb begin
    case (mode)
      1:       f = f_dly;
      2:       f = {1'b0, golden(vec)[0]};
      default: f = golden(vec) ^ flip_at(flip, int'(vec));
    endcase
  end
  assign f0 = f0_dly;

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Follows a running sweep from the first busy cycle; optionally pokes start or asserts rst.
  task automatic follow(input int poke_vec, input int rst_vec, output int cyc,
                        output bit seq_ok, output bit tmo);
    bit poked;
    poked = 1'b0; cyc = 0; seq_ok = 1'b1; tmo = 1'b0;
    while (busy === 1'b1) begin
      if (cyc >= 200) begin tmo = 1'b1; return; end
      if (vec !== 4'(cyc / 3)) seq_ok = 1'b0;
      if (rst_vec >= 0 && int'(vec) == rst_vec) begin
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        return;
      end
      if (poke_vec >= 0 && int'(vec) == poke_vec && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      cyc++;
      @(negedge clk) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; start0 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (vec !== 4'd0) begin errors++; $display("FAIL rst_vec: got %0d want 0", vec); end
    checks++; if (done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL rst_done_pass: got %b%b want 00", done, pass); end
    checks++; if (err !== 5'd0 || first !== 4'd0) begin errors++; $display("FAIL rst_counters: got err=%0d first=%0d want 0 0", err, first); end
    checks++; if (busy0 !== 1'b0 || vec0 !== 4'd0) begin errors++; $display("FAIL rst_dut0: got busy=%b vec=%0d want 0 0", busy0, vec0); end
`ifdef SIGNATURE_EN
    checks++; if (sig !== 16'hFFFF) begin errors++; $display("FAIL rst_sig: got %h want ffff", sig); end
`endif
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_sweep();
    int cyc; bit seq_ok, tmo;
    mode = 0; flip = '0;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy_rise: got %b want 1", busy); end
    follow(-1, -1, cyc, seq_ok, tmo);
    checks++; if (tmo || cyc != 48) begin errors++; $display("FAIL clean_latency: got %0d cycles (timeout=%0b) want 48", cyc, tmo); end
    checks++; if (!seq_ok) begin errors++; $display("FAIL clean_vec_seq: got out-of-order vec_o want 0..15 held 3 cycles"); end
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL clean_done_pass: got %b%b want 11", done, pass); end
    checks++; if (err !== 5'd0) begin errors++; $display("FAIL clean_err: got %0d want 0", err); end
`ifdef SIGNATURE_EN
    golden_sig = model_sig();
    checks++; if (sig !== golden_sig) begin errors++; $display("FAIL clean_sig: got %h want %h", sig, golden_sig); end
    repeat (3) @(negedge clk);
    checks++; if (sig !== golden_sig) begin errors++; $display("FAIL sig_frozen: got %h want %h", sig, golden_sig); end
`endif
  endtask

  task automatic test_stuck_f2();
    int cyc; bit seq_ok, tmo;
    mode = 2;
    pulse_start();
    follow(-1, -1, cyc, seq_ok, tmo);
    checks++; if (tmo || done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL stuck_done_pass: got %b%b want 10", done, pass); end
    checks++; if (err !== 5'd4) begin errors++; $display("FAIL stuck_err: got %0d want 4", err); end
    checks++; if (first !== 4'd3) begin errors++; $display("FAIL stuck_first: got %0d want 3", first); end
`ifdef SIGNATURE_EN
    checks++; if (sig !== model_sig()) begin errors++; $display("FAIL stuck_sig: got %h want %h", sig, model_sig()); end
    checks++; if (sig === golden_sig) begin errors++; $display("FAIL stuck_sig_differs: got %h want not %h", sig, golden_sig); end
`endif
  endtask

  task automatic test_back_to_back();
    int cyc; bit seq_ok, tmo;
    mode = 0; flip = '0;
    pulse_start();
    checks++; if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart_flags: got done=%b pass=%b busy=%b want 0 0 1", done, pass, busy); end
    checks++; if (err !== 5'd0 || first !== 4'd0) begin errors++; $display("FAIL restart_clear: got err=%0d first=%0d want 0 0", err, first); end
    follow(5, -1, cyc, seq_ok, tmo);
    checks++; if (tmo || cyc != 48 || !seq_ok) begin errors++; $display("FAIL busy_start_ignored: got %0d cycles seq_ok=%0b want 48 1", cyc, seq_ok); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL busy_start_pass: got %b want 1", pass); end
  endtask

  task automatic test_mid_reset();
    int cyc; bit seq_ok, tmo;
    mode = 0; flip = '0;
    pulse_start();
    follow(-1, 7, cyc, seq_ok, tmo);
    checks++; if (vec !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got vec=%0d busy=%b done=%b want 0 0 0", vec, busy, done); end
    checks++; if (err !== 5'd0 || first !== 4'd0 || pass !== 1'b0) begin errors++; $display("FAIL midrst_counters: got err=%0d first=%0d pass=%b want 0 0 0", err, first, pass); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_idle: got busy=%b done=%b want 0 0", busy, done); end
    pulse_start();
    follow(-1, -1, cyc, seq_ok, tmo);
    checks++; if (tmo || cyc != 48 || pass !== 1'b1 || err !== 5'd0) begin errors++; $display("FAIL midrst_resweep: got %0d cycles pass=%b err=%0d want 48 1 0", cyc, pass, err); end
  endtask

  task automatic test_random_faults();
    int cyc, exp_err, exp_first; bit seq_ok, tmo;
    mode = 0;
    for (int it = 0; it < 8; it++) begin
      flip = (it == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
      exp_err = 0; exp_first = 0;
      for (int i = 0; i < 16; i++) begin
        if (flip_at(flip, i) != 2'b00) begin
          if (exp_err == 0) exp_first = i;
          exp_err++;
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_start();
      follow(-1, -1, cyc, seq_ok, tmo);
      checks++; if (tmo || cyc != 48) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 48", it, cyc); end
      checks++; if (int'(err) != exp_err) begin errors++; $display("FAIL rand_err[%0d]: got %0d want %0d (flip=%h)", it, err, exp_err, flip); end
      checks++; if (pass !== (exp_err == 0)) begin errors++; $display("FAIL rand_pass[%0d]: got %b want %b", it, pass, exp_err == 0); end
      if (exp_err != 0) begin
        checks++; if (int'(first) != exp_first) begin errors++; $display("FAIL rand_first[%0d]: got %0d want %0d", it, first, exp_first); end
      end
`ifdef SIGNATURE_EN
      checks++; if (sig !== model_sig()) begin errors++; $display("FAIL rand_sig[%0d]: got %h want %h", it, sig, model_sig()); end
`endif
    end
    flip = '0;
  endtask

  task automatic test_output_delay();
    int cyc, exp_err, exp_first; bit seq_ok, tmo;
    logic [1:0] seen [16];
    mode = 1;
    pulse_start();
    follow(-1, -1, cyc, seq_ok, tmo);
    checks++; if (tmo || cyc != 48 || pass !== 1'b1 || err !== 5'd0) begin errors++; $display("FAIL delay_settle2: got %0d cycles pass=%b err=%0d want 48 1 0", cyc, pass, err); end
    // SETTLE=0: each sample sees the response to the previous vector (vector 0 was idle before start).
    exp_err = 0; exp_first = 0;
    for (int k = 0; k < 16; k++) begin
      seen[k] = golden(4'((k == 0) ? 0 : k - 1));
      if (seen[k] != golden(4'(k))) begin
        if (exp_err == 0) exp_first = k;
        exp_err++;
      end
    end
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    cyc = 0; seq_ok = 1'b1;
    while (busy0 === 1'b1 && cyc < 100) begin
      if (vec0 !== 4'(cyc)) seq_ok = 1'b0;
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc != 16 || !seq_ok) begin errors++; $display("FAIL settle0_latency: got %0d cycles seq_ok=%0b want 16 1", cyc, seq_ok); end
    checks++; if (done0 !== 1'b1 || pass0 !== 1'b0) begin errors++; $display("FAIL settle0_done_pass: got %b%b want 10", done0, pass0); end
    checks++; if (int'(err0) != exp_err || err0 === 5'd0) begin errors++; $display("FAIL settle0_err: got %0d want %0d", err0, exp_err); end
    checks++; if (int'(first0) != exp_first) begin errors++; $display("FAIL settle0_first: got %0d want %0d", first0, exp_first); end
`ifdef SIGNATURE_EN
    checks++; if (sig0 !== misr_ref(seen)) begin errors++; $display("FAIL settle0_sig: got %h want %h", sig0, misr_ref(seen)); end
`endif
  endtask

  initial begin
    mode = 0; flip = '0; rst = 1'b1; start = 1'b0; start0 = 1'b0;
    test_reset();
    test_clean_sweep();
    test_stuck_f2();
    test_back_to_back();
    test_mid_reset();
    test_random_faults();
    test_output_delay();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
